// File: rtl/pipe_stage_regs.sv
// F->D->E->M pipeline register bank that obeys the hazard unit's stall/flush,
// plus saturating stall/flush event counters for performance debug.
module pipe_stage_regs #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrF,
    input  logic [PC_W-1:0]  pcF,
    input  logic [3:0]       rsD_in,
    input  logic [3:0]       rtD_in,
    input  logic [3:0]       rdD_in,
    input  logic             loadD,
    input  logic             regWriteD,
    input  logic             branchD,
    input  logic             takenE,
    input  logic             stall,
    input  logic             flush,
    output logic             stallF,
    output logic [31:0]      instrD,
    output logic [PC_W-1:0]  pcD,
    output logic [3:0]       rsD,
    output logic [3:0]       rtD,
    output logic [3:0]       rsE,
    output logic [3:0]       rtE,
    output logic [3:0]       destRegE,
    output logic             loadE,
    output logic [3:0]       rdM,
    output logic             writeM,
    output logic             branch_M,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // F/D
    logic [31:0]      fd_instr_q, fd_instr_d;
    logic [PC_W-1:0]  fd_pc_q, fd_pc_d;
    logic             fd_valid_q, fd_valid_d;
    // D/E
    logic [3:0]       de_rs_q, de_rs_d, de_rt_q, de_rt_d, de_rd_q, de_rd_d;
    logic             de_load_q, de_load_d, de_write_q, de_write_d;
    logic             de_branch_q, de_branch_d, de_valid_q, de_valid_d;
    // E/M
    logic [3:0]       em_rd_q, em_rd_d;
    logic             em_write_q, em_write_d, em_branch_q, em_branch_d;
    logic             em_taken_q, em_taken_d, em_valid_q, em_valid_d;
    // counters
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic stall_only;
    assign stall_only = stall & ~flush;

    always_comb begin
        fd_instr_d  = fd_instr_q;
        fd_pc_d     = fd_pc_q;
        fd_valid_d  = fd_valid_q;
        de_rs_d     = '0;
        de_rt_d     = '0;
        de_rd_d     = '0;
        de_load_d   = 1'b0;
        de_write_d  = 1'b0;
        de_branch_d = 1'b0;
        de_valid_d  = 1'b0;
        em_rd_d     = '0;
        em_write_d  = 1'b0;
        em_branch_d = 1'b0;
        em_taken_d  = 1'b0;
        em_valid_d  = 1'b0;

        if (flush) begin
            // Every younger stage is wrong-path: all three load bubbles.
            fd_instr_d = '0;
            fd_pc_d    = '0;
            fd_valid_d = 1'b0;
        end else begin
            em_rd_d     = de_rd_q;
            em_write_d  = de_write_q;
            em_branch_d = de_branch_q;
            em_taken_d  = takenE & de_valid_q;
            em_valid_d  = de_valid_q;
            if (!stall) begin
                // Decoded fields are qualified so a bubble never looks like a hazard.
                de_rs_d     = fd_valid_q ? rsD_in : 4'd0;
                de_rt_d     = fd_valid_q ? rtD_in : 4'd0;
                de_rd_d     = fd_valid_q ? rdD_in : 4'd0;
                de_load_d   = loadD & fd_valid_q;
                de_write_d  = regWriteD & fd_valid_q;
                de_branch_d = branchD & fd_valid_q;
                de_valid_d  = fd_valid_q;
                fd_instr_d  = instrF;
                fd_pc_d     = pcF;
                fd_valid_d  = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_only && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fd_instr_q  <= '0;
            fd_pc_q     <= '0;
            fd_valid_q  <= 1'b0;
            de_rs_q     <= '0;
            de_rt_q     <= '0;
            de_rd_q     <= '0;
            de_load_q   <= 1'b0;
            de_write_q  <= 1'b0;
            de_branch_q <= 1'b0;
            de_valid_q  <= 1'b0;
            em_rd_q     <= '0;
            em_write_q  <= 1'b0;
            em_branch_q <= 1'b0;
            em_taken_q  <= 1'b0;
            em_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fd_instr_q  <= fd_instr_d;
            fd_pc_q     <= fd_pc_d;
            fd_valid_q  <= fd_valid_d;
            de_rs_q     <= de_rs_d;
            de_rt_q     <= de_rt_d;
            de_rd_q     <= de_rd_d;
            de_load_q   <= de_load_d;
            de_write_q  <= de_write_d;
            de_branch_q <= de_branch_d;
            de_valid_q  <= de_valid_d;
            em_rd_q     <= em_rd_d;
            em_write_q  <= em_write_d;
            em_branch_q <= em_branch_d;
            em_taken_q  <= em_taken_d;
            em_valid_q  <= em_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // stallF is the only output allowed a combinational path from stall/flush.
    assign stallF    = stall_only & ~reset;
    assign instrD    = fd_instr_q;
    assign pcD       = fd_pc_q;
    assign rsD       = fd_valid_q ? rsD_in : 4'd0;
    assign rtD       = fd_valid_q ? rtD_in : 4'd0;
    assign rsE       = de_rs_q;
    assign rtE       = de_rt_q;
    assign destRegE  = de_rd_q;
    assign loadE     = de_load_q & de_valid_q;
    assign rdM       = em_rd_q;
    assign writeM    = em_write_q & em_valid_q;
    assign branch_M  = em_valid_q & em_branch_q & em_taken_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Scoreboard bench for pipe_stage_regs: directed hazard scenarios then random
// traffic, all checked against an instruction-level pipeline model.
module tb_pipe_stage_regs;

    localparam int CntMax = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrF, pcF;
    logic [3:0]  rsD_in, rtD_in, rdD_in;
    logic        loadD, regWriteD, branchD, takenE, stall, flush;
    logic        stallF, loadE, writeM, branch_M;
    logic [31:0] instrD, pcD;
    logic [3:0]  rsD, rtD, rsE, rtE, destRegE, rdM;
    logic [3:0]  stall_cnt, flush_cnt;

    pipe_stage_regs #(.PC_W(32), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .instrF(instrF), .pcF(pcF),
        .rsD_in(rsD_in), .rtD_in(rtD_in), .rdD_in(rdD_in),
        .loadD(loadD), .regWriteD(regWriteD), .branchD(branchD), .takenE(takenE),
        .stall(stall), .flush(flush), .stallF(stallF), .instrD(instrD), .pcD(pcD),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .destRegE(destRegE),
        .loadE(loadE), .rdM(rdM), .writeM(writeM), .branch_M(branch_M),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] ins, pc;
        logic [3:0]  rs, rt, rd;
        logic        ld, wr, br, tk, st, fl;
    } stim_t;

    typedef struct {
        logic        stallF;
        logic [31:0] instrD, pcD;
        logic [3:0]  rsD, rtD, rsE, rtE, destRegE, rdM;
        logic        loadE, writeM, branch_M;
        int          sc, fc;
    } exp_t;

    // One in-flight instruction as the model sees it; valid=0 is a bubble.
    typedef struct {
        logic        v;
        logic [31:0] ins, pc;
        logic [3:0]  rs, rt, rd;
        logic        ld, wr, br, tk;
    } slot_t;

    slot_t sd, se, sm, bubble;
    int    m_sc, m_fc;
    exp_t  sb[$];
    stim_t cur;
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Advance the model by one clock using the stimulus that was held during the cycle.
    function automatic void model_edge(stim_t s);
        slot_t nd;
        if (s.rst) begin
            sd = bubble; se = bubble; sm = bubble; m_sc = 0; m_fc = 0;
        end else if (s.fl) begin
            sd = bubble; se = bubble; sm = bubble;
            m_fc = (m_fc < CntMax) ? m_fc + 1 : CntMax;
        end else begin
            if (s.st) m_sc = (m_sc < CntMax) ? m_sc + 1 : CntMax;
            sm = se;
            if (se.v) sm.tk = s.tk;
            if (s.st || !sd.v) begin
                se = bubble;
            end else begin
                se = sd;
                se.rs = s.rs; se.rt = s.rt; se.rd = s.rd;
                se.ld = s.ld; se.wr = s.wr; se.br = s.br;
            end
            if (!s.st) begin
                nd = bubble;
                nd.v = 1'b1; nd.ins = s.ins; nd.pc = s.pc;
                sd = nd;
            end
        end
    endfunction

    function automatic exp_t model_out(stim_t s);
        exp_t e;
        e.stallF   = s.st && !s.fl && !s.rst;
        e.instrD   = sd.v ? sd.ins : 32'd0;
        e.pcD      = sd.v ? sd.pc : 32'd0;
        e.rsD      = sd.v ? s.rs : 4'd0;
        e.rtD      = sd.v ? s.rt : 4'd0;
        e.rsE      = se.v ? se.rs : 4'd0;
        e.rtE      = se.v ? se.rt : 4'd0;
        e.destRegE = se.v ? se.rd : 4'd0;
        e.loadE    = se.v && se.ld;
        e.rdM      = sm.v ? sm.rd : 4'd0;
        e.writeM   = sm.v && sm.wr;
        e.branch_M = sm.v && sm.br && sm.tk;
        e.sc       = m_sc;
        e.fc       = m_fc;
        return e;
    endfunction

    task automatic drive(stim_t s);
        reset = s.rst; instrF = s.ins; pcF = s.pc;
        rsD_in = s.rs; rtD_in = s.rt; rdD_in = s.rd;
        loadD = s.ld; regWriteD = s.wr; branchD = s.br; takenE = s.tk;
        stall = s.st; flush = s.fl;
    endtask

    task automatic cyc(stim_t s);
        @(posedge clk);
        #1;
        model_edge(cur);
        cur = s;
        drive(cur);
        sb.push_back(model_out(cur));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle once the scoreboard has an entry.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stallF", stallF, e.stallF);
            chk("instrD", instrD, e.instrD);
            chk("pcD", pcD, e.pcD);
            chk("rsD", rsD, e.rsD);
            chk("rtD", rtD, e.rtD);
            chk("rsE", rsE, e.rsE);
            chk("rtE", rtE, e.rtE);
            chk("destRegE", destRegE, e.destRegE);
            chk("loadE", loadE, e.loadE);
            chk("rdM", rdM, e.rdM);
            chk("writeM", writeM, e.writeM);
            chk("branch_M", branch_M, e.branch_M);
            chk("stall_cnt", stall_cnt, e.sc[3:0]);
            chk("flush_cnt", flush_cnt, e.fc[3:0]);
        end
    end

    initial begin
        stim_t s, z;
        z = '{default: '0};
        bubble = '{default: '0};
        sd = bubble; se = bubble; sm = bubble; m_sc = 0; m_fc = 0;

        // Reset for two cycles with a live instruction on the fetch bus.
        s = z; s.rst = 1'b1; s.ins = 32'hE3A01005; s.pc = 32'h40;
        cur = s;
        drive(cur);
        cyc(s);
        s = z; s.ins = 32'hE5912000; s.pc = 32'h100;          // LDR r2
        cyc(s);
        settle();
        chk("rst_instrD", instrD, 32'd0);
        chk("rst_destRegE", destRegE, 4'd0);
        chk("rst_loadE", loadE, 1'b0);
        chk("rst_writeM", writeM, 1'b0);
        chk("rst_branch_M", branch_M, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 4'd0);

        // LDR r2 in D, ADD r3,r2,r4 fetched.
        s = z; s.ins = 32'hE0823004; s.pc = 32'h104; s.rd = 4'd2; s.ld = 1'b1; s.wr = 1'b1;
        cyc(s);
        // ADD in D, LDR in E: load-use stall for one cycle.
        s = z; s.ins = 32'hE1A00000; s.pc = 32'h108;
        s.rs = 4'd2; s.rt = 4'd4; s.rd = 4'd3; s.wr = 1'b1; s.st = 1'b1;
        cyc(s);
        settle();
        chk("lu_loadE", loadE, 1'b1);
        chk("lu_destRegE", destRegE, 4'd2);
        chk("lu_stallF", stallF, 1'b1);
        s.st = 1'b0;
        cyc(s);
        settle();
        chk("lu_instrD_held", instrD, 32'hE0823004);
        chk("lu_bubble_loadE", loadE, 1'b0);
        chk("lu_bubble_dest", destRegE, 4'd0);
        chk("lu_stall_cnt", stall_cnt, 4'd1);

        // Taken branch: fetch, decode, resolve in E, reaches M, hazard unit flushes.
        s = z; s.ins = 32'hEA000010; s.pc = 32'h200;
        cyc(s);
        s = z; s.ins = 32'hE2811001; s.pc = 32'h204; s.br = 1'b1;
        cyc(s);
        s = z; s.ins = 32'hE2822001; s.pc = 32'h208; s.rd = 4'd1; s.wr = 1'b1; s.tk = 1'b1;
        cyc(s);
        s = z; s.ins = 32'hE2833001; s.pc = 32'h20C; s.rd = 4'd2; s.wr = 1'b1; s.fl = 1'b1;
        cyc(s);
        settle();
        chk("br_branch_M", branch_M, 1'b1);
        chk("br_stallF", stallF, 1'b0);
        s = z; s.ins = 32'hE3A00000; s.pc = 32'h240;
        cyc(s);
        settle();
        chk("fl_instrD", instrD, 32'd0);
        chk("fl_loadE", loadE, 1'b0);
        chk("fl_writeM", writeM, 1'b0);
        chk("fl_branch_M", branch_M, 1'b0);
        chk("fl_flush_cnt", flush_cnt, 4'd1);

        // Stall and flush together: flush wins.
        s = z; s.ins = 32'hE3A00001; s.pc = 32'h244; s.st = 1'b1; s.fl = 1'b1;
        cyc(s);
        settle();
        chk("sf_stallF", stallF, 1'b0);
        s = z; s.ins = 32'hE3A00002; s.pc = 32'h248;
        cyc(s);
        settle();
        chk("sf_instrD", instrD, 32'd0);
        chk("sf_flush_cnt", flush_cnt, 4'd2);
        chk("sf_stall_cnt", stall_cnt, 4'd1);

        // Saturation: 20 stall cycles on a 4-bit counter.
        s.st = 1'b1;
        for (int i = 0; i < 20; i++) cyc(s);
        s.st = 1'b0;
        cyc(s);
        settle();
        chk("sat_stall_cnt", stall_cnt, 4'd15);

        // Reset in the middle of a stall sequence.
        s = z; s.ins = 32'hE3A00003; s.pc = 32'h300; s.st = 1'b1;
        cyc(s);
        cyc(s);
        s.rst = 1'b1;
        cyc(s);
        settle();
        chk("rs_stallF", stallF, 1'b0);
        s.rst = 1'b0;
        cyc(s);
        settle();
        chk("rs_stall_cnt", stall_cnt, 4'd0);
        chk("rs_flush_cnt", flush_cnt, 4'd0);
        chk("rs_instrD", instrD, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            s.rst = ($urandom_range(0, 99) < 2);
            s.ins = $urandom;
            s.pc  = $urandom;
            s.rs  = 4'($urandom);
            s.rt  = 4'($urandom);
            s.rd  = 4'($urandom);
            s.ld  = 1'($urandom);
            s.wr  = 1'($urandom);
            s.br  = 1'($urandom);
            s.tk  = 1'($urandom);
            s.st  = ($urandom_range(0, 99) < 25);
            s.fl  = ($urandom_range(0, 99) < 12);
            cyc(s);
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
